// File: rtl/bank_cmd_scheduler.sv
// bank_cmd_scheduler
//   Turns one decoded memory request at a time into a DDR4 command stream
//   (PRECHARGE / ACTIVATE / READ / WRITE). The scheduler keeps an open-page
//   table per bank and enforces precharge, activation and column-to-column
//   spacing.
//
// Ports
//   clk_in          clock, rising edge
//   rst_in          asynchronous active-high reset
//   req_valid_in    request present
//   req_ready_out   scheduler can accept a request (high only in IDLE)
//   req_bg_in       request bank group
//   req_ba_in       request bank
//   req_row_in      request row
//   req_col_in      request column
//   req_write_in    1 = write, 0 = read
//   cmd_valid_out   a command is presented on cmd_* this cycle
//   cmd_out         0 READ, 1 WRITE, 2 ACTIVATE, 3 PRECHARGE
//   bg_out, ba_out  command bank group / bank
//   row_out         row, meaningful for ACTIVATE
//   col_out         column, meaningful for READ/WRITE
//   row_hit_out     pulses with a column command whose request hit an open row
//
// State table
//   state       | meaning
//   S_IDLE      | ready for a request
//   S_DECIDE    | classify latched request against the bank table
//   S_PRE       | issue PRECHARGE, close the bank
//   S_PRE_WAIT  | wait out precharge latency
//   S_ACT       | issue ACTIVATE, open the requested row
//   S_ACT_WAIT  | wait out activation latency
//   S_COL       | issue READ/WRITE once the column gap has elapsed

module bank_cmd_scheduler #(
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int BURST_CYCLES       = 4,
    parameter int BANK_GROUPS        = 8,
    parameter int BANKS_PER_GROUP    = 8,
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               req_valid_in,
    output logic                               req_ready_out,
    input  logic [$clog2(BANK_GROUPS)-1:0]     req_bg_in,
    input  logic [$clog2(BANKS_PER_GROUP)-1:0] req_ba_in,
    input  logic [ROW_BITS-1:0]                req_row_in,
    input  logic [COL_BITS-1:0]                req_col_in,
    input  logic                               req_write_in,
    output logic                               cmd_valid_out,
    output logic [2:0]                         cmd_out,
    output logic [$clog2(BANK_GROUPS)-1:0]     bg_out,
    output logic [$clog2(BANKS_PER_GROUP)-1:0] ba_out,
    output logic [ROW_BITS-1:0]                row_out,
    output logic [COL_BITS-1:0]                col_out,
    output logic                               row_hit_out
);

    localparam int BG_W      = $clog2(BANK_GROUPS);
    localparam int BA_W      = $clog2(BANKS_PER_GROUP);
    localparam int IDX_W     = BG_W + BA_W;
    localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int WAIT_MAX  = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                               ACTIVATION_LATENCY : PRECHARGE_LATENCY;
    localparam int WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam int GAP_W     = $clog2(BURST_CYCLES + 1);

    localparam logic [2:0] CMD_READ  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_ACT   = 3'd2;
    localparam logic [2:0] CMD_PRE   = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_PRE,
        S_PRE_WAIT,
        S_ACT,
        S_ACT_WAIT,
        S_COL
    } state_t;

    state_t              state, state_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;
    logic [GAP_W-1:0]    gap_cnt;

    logic [BG_W-1:0]     lat_bg;
    logic [BA_W-1:0]     lat_ba;
    logic [ROW_BITS-1:0] lat_row;
    logic [COL_BITS-1:0] lat_col;
    logic                lat_write;
    logic                lat_hit, hit_next;

    logic [NUM_BANKS-1:0] open_bits;
    logic [ROW_BITS-1:0]  open_row [NUM_BANKS];

    logic [IDX_W-1:0]    idx;
    logic                accept;
    logic                issue;
    logic                col_issue;
    logic [2:0]          issue_cmd;
    logic                set_open;
    logic                clr_open;

    assign idx           = {lat_bg, lat_ba};
    assign req_ready_out = (state == S_IDLE);

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        hit_next   = lat_hit;
        accept     = 1'b0;
        issue      = 1'b0;
        col_issue  = 1'b0;
        issue_cmd  = CMD_READ;
        set_open   = 1'b0;
        clr_open   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid_in) begin
                    accept     = 1'b1;
                    state_next = S_DECIDE;
                end
            end
            S_DECIDE: begin
                hit_next = 1'b0;
                if (open_bits[idx] && (open_row[idx] == lat_row)) begin
                    hit_next   = 1'b1;
                    state_next = S_COL;
                end else if (open_bits[idx]) begin
                    state_next = S_PRE;
                end else begin
                    state_next = S_ACT;
                end
            end
            S_PRE: begin
                issue     = 1'b1;
                issue_cmd = CMD_PRE;
                clr_open  = 1'b1;
                wait_next = WAIT_W'(PRECHARGE_LATENCY - 1);
                // A one-cycle latency leaves nothing to wait for.
                if (PRECHARGE_LATENCY > 1) state_next = S_PRE_WAIT;
                else                       state_next = S_ACT;
            end
            S_PRE_WAIT: begin
                wait_next = wait_cnt - WAIT_W'(1);
                if (wait_cnt <= WAIT_W'(1)) state_next = S_ACT;
            end
            S_ACT: begin
                issue     = 1'b1;
                issue_cmd = CMD_ACT;
                set_open  = 1'b1;
                wait_next = WAIT_W'(ACTIVATION_LATENCY - 1);
                if (ACTIVATION_LATENCY > 1) state_next = S_ACT_WAIT;
                else                        state_next = S_COL;
            end
            S_ACT_WAIT: begin
                wait_next = wait_cnt - WAIT_W'(1);
                if (wait_cnt <= WAIT_W'(1)) state_next = S_COL;
            end
            S_COL: begin
                if (gap_cnt == '0) begin
                    issue      = 1'b1;
                    col_issue  = 1'b1;
                    issue_cmd  = lat_write ? CMD_WRITE : CMD_READ;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            gap_cnt       <= '0;
            lat_bg        <= '0;
            lat_ba        <= '0;
            lat_row       <= '0;
            lat_col       <= '0;
            lat_write     <= 1'b0;
            lat_hit       <= 1'b0;
            open_bits     <= '0;
            cmd_valid_out <= 1'b0;
            cmd_out       <= '0;
            bg_out        <= '0;
            ba_out        <= '0;
            row_out       <= '0;
            col_out       <= '0;
            row_hit_out   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            lat_hit  <= hit_next;

            if (accept) begin
                lat_bg    <= req_bg_in;
                lat_ba    <= req_ba_in;
                lat_row   <= req_row_in;
                lat_col   <= req_col_in;
                lat_write <= req_write_in;
            end

            // Gap counter runs independently of the FSM so spacing carries
            // over from one request to the next.
            if (col_issue)           gap_cnt <= GAP_W'(BURST_CYCLES - 1);
            else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GAP_W'(1);

            if (clr_open) open_bits[idx] <= 1'b0;
            if (set_open) open_bits[idx] <= 1'b1;

            cmd_valid_out <= issue;
            row_hit_out   <= col_issue & lat_hit;
            if (issue) begin
                cmd_out <= issue_cmd;
                bg_out  <= lat_bg;
                ba_out  <= lat_ba;
            end
            if (set_open)  row_out <= lat_row;
            if (col_issue) col_out <= lat_col;
        end
    end

    // Row fields survive precharge and reset; only the open bit decides hits.
    always_ff @(posedge clk_in) begin
        if (set_open) open_row[idx] <= lat_row;
    end

endmodule
